// File: rtl/seq_sm_mult_ctrl_if.sv
// Request/result bundle between the multiply requester and seq_sm_mult_ctrl.
// Operands and product are sign-magnitude, with the sign in the MSB.
interface seq_sm_mult_ctrl_if #(parameter int N = 4);
  logic         start;
  logic [N:0]   x;
  logic [N:0]   y;
  logic         ready;
  logic         busy;
  logic         done;
  logic [2*N:0] prod;

  modport master (output start, x, y, input ready, busy, done, prod);
  modport slave  (input start, x, y, output ready, busy, done, prod);
endinterface

// File: rtl/seq_sm_mult_ctrl.sv
// Sequential sign-magnitude shift-add multiplier: one multiplier bit per clock,
// fixed N-cycle latency, registered one-cycle done pulse with a held product.
module seq_sm_mult_ctrl #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_sm_mult_ctrl_if.slave  bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, ACC} state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           s;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [CW-1:0]  count;
  logic           last;
  logic           done_q;
  logic [2*N:0]   prod_q;

  assign last = (count == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ACC;
      ACC:     if (last)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    case (state)
      IDLE:    bus.ready = 1'b1;
      ACC:     bus.busy  = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  // Zero-extended shifted multiplicand always fits in 2N bits, so no carry out.
  always_comb begin
    acc_next = acc;
    if (b[count]) acc_next = acc + ({{N{1'b0}}, a} << count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      s      <= 1'b0;
      acc    <= '0;
      count  <= '0;
      done_q <= 1'b0;
      prod_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a     <= bus.x[N-1:0];
            b     <= bus.y[N-1:0];
            s     <= bus.x[N] ^ bus.y[N];
            acc   <= '0;
            count <= '0;
          end
        end
        ACC: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (last) begin
            prod_q <= {s, acc_next};
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done = done_q;
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_seq_sm_mult_ctrl.sv
// Directed bench for seq_sm_mult_ctrl (N=4): hand-computed products, latency,
// busy-start rejection, back-to-back issue and asynchronous mid-operation reset.
module tb_seq_sm_mult_ctrl;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_sm_mult_ctrl_if #(.N(N)) bus ();

  seq_sm_mult_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [N:0] xv,
                               input logic [N:0] yv);
    bus.start = st;
    bus.x     = xv;
    bus.y     = yv;
  endtask

  // Issues one operation and returns at the negedge where done is visible.
  task automatic runOp(input string tag, input logic [N:0] xv,
                       input logic [N:0] yv, input logic [2*N:0] expProd);
    int cyc;
    int busyCount;
    int readyHigh;
    @(negedge clk);
    applyStimulus(1'b1, xv, yv);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    cyc = 0;
    busyCount = 0;
    readyHigh = 0;
    while (bus.done !== 1'b1 && cyc < 12) begin
      if (bus.busy === 1'b1) busyCount++;
      if (bus.ready !== 1'b0) readyHigh++;
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, "_latency"}, cyc, N);
    checkOutput({tag, "_busycycles"}, busyCount, N);
    checkOutput({tag, "_readylow"}, readyHigh, 0);
    checkOutput({tag, "_prod"}, 32'(bus.prod), 32'(expProd));
    checkOutput({tag, "_readyback"}, 32'(bus.ready), 32'd1);
    checkOutput({tag, "_busyoff"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int doneCount;
    int busyCount;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0);

    #1;
    checkOutput("rst_ready", 32'(bus.ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_prod", 32'(bus.prod), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 32'(bus.ready), 32'd1);

    // 3 * -5 = -15
    runOp("basic", 5'b0_0011, 5'b1_0101, 9'b1_0000_1111);
    @(negedge clk);
    checkOutput("basic_donepulse", 32'(bus.done), 32'd0);
    checkOutput("basic_prodhold", 32'(bus.prod), 32'h10F);

    // -15 * -15 = 225
    runOp("max", 5'b1_1111, 5'b1_1111, 9'b0_1110_0001);

    // -0 * 7 keeps the sign bit
    runOp("zerosign", 5'b1_0000, 5'b0_0111, 9'b1_0000_0000);

    // start during busy cycle 2 must be ignored
    @(negedge clk);
    applyStimulus(1'b1, 5'b0_0010, 5'b0_0011);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    checkOutput("ign_busy1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 5'b0_1111, 5'b0_1111);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    cyc = 2;
    while (bus.done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ign_latency", cyc, N);
    checkOutput("ign_prod", 32'(bus.prod), 32'h006);
    doneCount = 0;
    busyCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneCount++;
      if (bus.busy === 1'b1) busyCount++;
    end
    checkOutput("ign_extradone", doneCount, 0);
    checkOutput("ign_extrabusy", busyCount, 0);
    checkOutput("ign_prodhold", 32'(bus.prod), 32'h006);

    // back-to-back: 6*3=18, then 4*4=16 issued in the done cycle
    runOp("b2b_first", 5'b0_0110, 5'b0_0011, 9'b0_0001_0010);
    applyStimulus(1'b1, 5'b0_0100, 5'b0_0100);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    cyc = 1;
    checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_spacing", cyc, N + 1);
    checkOutput("b2b_prod", 32'(bus.prod), 32'h010);

    // asynchronous reset in busy cycle 2
    @(negedge clk);
    applyStimulus(1'b1, 5'b0_0011, 5'b0_0011);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    checkOutput("mid_busy2", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_ready", 32'(bus.ready), 32'd1);
    checkOutput("mid_done", 32'(bus.done), 32'd0);
    checkOutput("mid_prod", 32'(bus.prod), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("postrst", 5'b0_0001, 5'b0_0001, 9'b0_0000_0001);
    @(negedge clk);
    checkOutput("postrst_donepulse", 32'(bus.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
